// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control unit: fetch/decode/execute sequencing, pc and writeback control.
// Optional retire counter output enabled by defining RETIRE_CNT_EN.
module cpu_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ir,
    input  logic [4:0]  dec_type,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic        br_taken,
    input  logic [15:0] rf_src,
    input  logic [15:0] ret_addr,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [15:0] mdr,
    output logic [15:0] pc
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    localparam int unsigned W     = 16;
    localparam int unsigned IMM_W = 8;
    localparam int unsigned CNT_W = 32;

    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [3:0] OP_LD   = 4'b1011;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1101;
    localparam logic [3:0] OP_CALL = 4'b1110;
    localparam logic [3:0] OP_RET  = 4'b1111;

    localparam logic [4:0] DT_NOP = 5'b00000;
    localparam logic [4:0] DT_LDR = 5'b00100;
    localparam logic [4:0] DT_LDI = 5'b00101;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_IMM  = 2'b01;
    localparam logic [1:0] SEL_MDR  = 2'b10;
    localparam logic [1:0] SEL_LINK = 2'b11;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_REL  = 2'b01;
    localparam logic [1:0] PC_RET  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_ALU    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [1:0]    pc_act;
    logic [1:0]    sel_n;
    logic [3:0]    op;
    logic [W-1:0]  imm;
    logic          rd_ok;

    logic          mem_req_d, alu_start_d, rf_we_d;
    logic [W-1:0]  mem_addr_d, ir_d, mdr_d, pc_d;
    logic [1:0]    wb_sel_d;

    assign op    = ir[15:12];
    assign imm   = {{(W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    // Acks only count while our own request is on the bus, so stale acks after reset are dropped.
    assign rd_ok = mem_req && mem_ack;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            mem_req   <= 1'b0;
            mem_addr  <= RESET_PC;
            ir        <= '0;
            mdr       <= '0;
            pc        <= RESET_PC;
            alu_start <= 1'b0;
            rf_we     <= 1'b0;
            wb_sel    <= SEL_ALU;
        end else begin
            state     <= state_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            ir        <= ir_d;
            mdr       <= mdr_d;
            pc        <= pc_d;
            alu_start <= alu_start_d;
            rf_we     <= rf_we_d;
            wb_sel    <= wb_sel_d;
        end
    end

    // Next-state logic, including the pc action and writeback source chosen at dispatch.
    always_comb begin
        state_d = state;
        pc_act  = PC_HOLD;
        sel_n   = SEL_ALU;
        case (state)
            S_FETCH: begin
                if (rd_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_type == DT_NOP) begin
                    state_d = S_FETCH;
                end else if (dec_type == DT_LDI) begin
                    state_d = S_WB;
                    sel_n   = SEL_IMM;
                end else begin
                    case (op)
                        OP_LD: begin
                            state_d = (dec_type == DT_LDR) ? S_MEM : S_FETCH;
                        end
                        OP_BR: begin
                            state_d = S_FETCH;
                            if (br_taken) pc_act = PC_REL;
                        end
                        OP_JMP: begin
                            state_d = S_FETCH;
                            pc_act  = PC_REL;
                        end
                        OP_CALL: begin
                            state_d = S_WB;
                            pc_act  = PC_REL;
                            sel_n   = SEL_LINK;
                        end
                        OP_RET: begin
                            state_d = S_FETCH;
                            pc_act  = PC_RET;
                        end
                        default: state_d = S_ALU;
                    endcase
                end
            end
            S_ALU: begin
                if (alu_done) state_d = (op == OP_CMP) ? S_FETCH : S_WB;
            end
            S_MEM: begin
                if (rd_ok) begin
                    state_d = S_WB;
                    sel_n   = SEL_MDR;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Next values of registered outputs and datapath registers.
    always_comb begin
        ir_d        = ir;
        mdr_d       = mdr;
        pc_d        = pc;
        wb_sel_d    = wb_sel;
        mem_addr_d  = mem_addr;
        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
        alu_start_d = (state == S_DECODE) && (state_d == S_ALU);
        rf_we_d     = (state_d == S_WB);

        if (state == S_FETCH && rd_ok) begin
            ir_d = mem_rdata;
            pc_d = pc + W'(1);
        end
        if (state == S_MEM && rd_ok) mdr_d = mem_rdata;

        case (pc_act)
            PC_REL:  pc_d = pc + imm;
            PC_RET:  pc_d = ret_addr;
            default: ;
        endcase

        // wb_sel is latched on WB entry and held until the next writeback.
        if (state_d == S_WB && state != S_WB) wb_sel_d = sel_n;

        if (state_d == S_FETCH) begin
            mem_addr_d = pc_d;
        end else if (state == S_DECODE && state_d == S_MEM) begin
            mem_addr_d = rf_src;
        end
    end

`ifdef RETIRE_CNT_EN
    // Counts completed instructions: every re-entry into FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (state_d == S_FETCH && state != S_FETCH) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a scoreboard of per-instruction expectations.
module tb_cpu_ctrl;

    localparam logic [15:0] RST_PC  = 16'h0000;
    localparam int          ALU_LAT = 3;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] mdr;
        int          starts;
        int          wes;
        logic [1:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] ir;
    logic [4:0]  dec_type;
    logic        alu_start;
    logic        alu_done;
    logic        br_taken = 1'b0;
    logic [15:0] rf_src = 16'h0000;
    logic [15:0] ret_addr = 16'h0000;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [15:0] mdr;
    logic [15:0] pc;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    logic alu_auto = 1'b1;
    logic alu_kick = 1'b0;
    logic auto_done = 1'b0;
    int   cd = 0;
    int   cnt_we = 0;
    int   cnt_start = 0;
    int   total = 0;
    int   bad = 0;
    logic [15:0] m_pc = RST_PC;
    int   m_ret = 0;
    exp_t sb[$];

    cpu_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ir        (ir),
        .dec_type  (dec_type),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .br_taken  (br_taken),
        .rf_src    (rf_src),
        .ret_addr  (ret_addr),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .mdr       (mdr),
        .pc        (pc)
`ifdef RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Decoder stand-in: all-zero word is NOP, LD form picked by bit 5.
    function automatic logic [4:0] dec_of(input logic [15:0] i);
        if (i == 16'h0000) return 5'b00000;
        if (i[15:12] == 4'b1011) return i[5] ? 5'b00101 : 5'b00100;
        return 5'b00001;
    endfunction
    assign dec_type = dec_of(ir);

    assign alu_done = alu_auto ? auto_done : alu_kick;

    // ALU model: done pulses ALU_LAT cycles after start.
    always @(negedge clk) begin
        if (alu_start) begin
            cd = ALU_LAT;
            auto_done = 1'b0;
        end else if (cd > 0) begin
            cd = cd - 1;
            auto_done = (cd == 0);
        end else begin
            auto_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rf_we === 1'b1) cnt_we = cnt_we + 1;
        if (alu_start === 1'b1) cnt_start = cnt_start + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] p, input logic [15:0] i, input logic [15:0] m,
                                input int s, input int w, input logic [1:0] sl);
        exp_t e;
        e.pc = p; e.ir = i; e.mdr = m; e.starts = s; e.wes = w; e.sel = sl;
        return e;
    endfunction

    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(mem_req), 32'd1);
    endtask

    task automatic serve(input logic [15:0] d, input int dly);
        repeat (dly) @(negedge clk);
        mem_rdata = d;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    task automatic exec(input string tag, input logic [15:0] instr, input int dly, input bit ldr,
                        input logic [15:0] ld_addr, input logic [15:0] ld_data, input exp_t e);
        exp_t got;
        int s0, w0;
        sb.push_back(e);
        wait_req(tag);
        check({tag, "_faddr"}, 32'(mem_addr), 32'(m_pc));
        s0 = cnt_start;
        w0 = cnt_we;
        serve(instr, dly);
        if (ldr) begin
            wait_req({tag, "_mem"});
            check({tag, "_maddr"}, 32'(mem_addr), 32'(ld_addr));
            serve(ld_data, 1);
        end
        wait_req({tag, "_next"});
        got = sb.pop_front();
        check({tag, "_pc"}, 32'(pc), 32'(got.pc));
        check({tag, "_ir"}, 32'(ir), 32'(got.ir));
        check({tag, "_mdr"}, 32'(mdr), 32'(got.mdr));
        check({tag, "_wbsel"}, 32'(wb_sel), 32'(got.sel));
        check({tag, "_starts"}, 32'(cnt_start - s0), 32'(got.starts));
        check({tag, "_wes"}, 32'(cnt_we - w0), 32'(got.wes));
        m_pc  = got.pc;
        m_ret = m_ret + 1;
`ifdef RETIRE_CNT_EN
        check({tag, "_retire"}, retire_cnt, 32'(m_ret));
`endif
    endtask

    initial begin
        int s0, w0, n;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 32'(RST_PC));
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_mdr", 32'(mdr), 32'h0);
        check("rst_wbsel", 32'(wb_sel), 32'h0);
        check("rst_memreq", 32'(mem_req), 32'h0);
        check("rst_alustart", 32'(alu_start), 32'h0);
        check("rst_rfwe", 32'(rf_we), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req", 32'(mem_req), 32'd1);
        check("post_rst_addr", 32'(mem_addr), 32'(RST_PC));

        // Reset in the middle of an ALU op; late alu_done must be ignored
        alu_auto = 1'b0;
        s0 = cnt_start;
        w0 = cnt_we;
        serve(16'h1283, 0);
        n = 0;
        while (alu_start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_saw_start", 32'(alu_start), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        alu_kick = 1'b1;
        @(negedge clk);
        alu_kick = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_pc", 32'(pc), 32'(RST_PC));
        check("abort_ir", 32'(ir), 32'h0);
        check("abort_req", 32'(mem_req), 32'd1);
        check("abort_addr", 32'(mem_addr), 32'(RST_PC));
        check("abort_wes", 32'(cnt_we - w0), 32'd0);
        check("abort_starts", 32'(cnt_start - s0), 32'd1);
`ifdef RETIRE_CNT_EN
        check("abort_retire", retire_cnt, 32'd0);
`endif
        alu_auto = 1'b1;

        // Reset during fetch followed by a stale ack
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rdata = 16'h1283;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        check("late_ack_ir", 32'(ir), 32'h0);
        check("late_ack_pc", 32'(pc), 32'(RST_PC));
        m_pc  = RST_PC;
        m_ret = 0;

        // Instruction stream
        exec("add",    16'h1283, 2, 1'b0, 16'h0, 16'h0, mk(16'h0001, 16'h1283, 16'h0000, 1, 1, 2'b00));
        exec("cmp",    16'hA123, 0, 1'b0, 16'h0, 16'h0, mk(16'h0002, 16'hA123, 16'h0000, 1, 0, 2'b00));
        exec("jmp_a",  16'hD00D, 1, 1'b0, 16'h0, 16'h0, mk(16'h0010, 16'hD00D, 16'h0000, 0, 0, 2'b00));
        br_taken = 1'b1;
        exec("br_t",   16'hC0FE, 0, 1'b0, 16'h0, 16'h0, mk(16'h000F, 16'hC0FE, 16'h0000, 0, 0, 2'b00));
        exec("jmp_b",  16'hD000, 0, 1'b0, 16'h0, 16'h0, mk(16'h0010, 16'hD000, 16'h0000, 0, 0, 2'b00));
        br_taken = 1'b0;
        exec("br_nt",  16'hC0FE, 0, 1'b0, 16'h0, 16'h0, mk(16'h0011, 16'hC0FE, 16'h0000, 0, 0, 2'b00));
        exec("jmp_c",  16'hD00E, 0, 1'b0, 16'h0, 16'h0, mk(16'h0020, 16'hD00E, 16'h0000, 0, 0, 2'b00));
        exec("call",   16'hE005, 1, 1'b0, 16'h0, 16'h0, mk(16'h0026, 16'hE005, 16'h0000, 0, 1, 2'b11));
        ret_addr = 16'h0021;
        exec("ret",    16'hF000, 0, 1'b0, 16'h0, 16'h0, mk(16'h0021, 16'hF000, 16'h0000, 0, 0, 2'b11));
        rf_src = 16'h1234;
        exec("ldr",    16'hB200, 0, 1'b1, 16'h1234, 16'hBEEF, mk(16'h0022, 16'hB200, 16'hBEEF, 0, 1, 2'b10));
        exec("ldi",    16'hB020, 0, 1'b0, 16'h0, 16'h0, mk(16'h0023, 16'hB020, 16'hBEEF, 0, 1, 2'b01));
        exec("nop",    16'h0000, 0, 1'b0, 16'h0, 16'h0, mk(16'h0024, 16'h0000, 16'hBEEF, 0, 0, 2'b01));
        exec("jmp_w",  16'hD0DA, 0, 1'b0, 16'h0, 16'h0, mk(16'hFFFF, 16'hD0DA, 16'hBEEF, 0, 0, 2'b01));
        exec("jmp_z",  16'hD000, 0, 1'b0, 16'h0, 16'h0, mk(16'h0000, 16'hD000, 16'hBEEF, 0, 0, 2'b01));
        exec("add2",   16'h1283, 0, 1'b0, 16'h0, 16'h0, mk(16'h0001, 16'h1283, 16'hBEEF, 1, 1, 2'b00));

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have ports: mem_req  out  1; mem_addr  out  16; mem_rdata  in  16; mem_ack  in  1  (read port, shared by fetch and LD).
REQ-005 SHALL have ports: ir  out  16  instruction register driving the decoder; dec_type  in  5  decoder type field.
REQ-006 SHALL have ports: alu_start  out  1; alu_done  in  1  (multi-cycle ALU handshake).
REQ-007 SHALL have ports: br_taken  in  1  branch condition; rf_src  in  16  SR1 read data; ret_addr  in  16  R7 read data.
REQ-008 SHALL have ports: rf_we  out  1; wb_sel  out  2  (00 ALU, 01 imm, 10 mdr, 11 link); mdr  out  16; pc  out  16.

Function
REQ-009 SHALL implement FSM states FETCH, DECODE, ALU, MEM, WB, with a single active state.
REQ-010 FETCH SHALL hold mem_req=1 and mem_addr=pc until mem_ack; on ack: ir<=mem_rdata, pc<=pc+1, go to DECODE. Minimum fetch latency SHALL be 1 cycle.
REQ-011 DECODE SHALL last exactly one cycle and dispatch on ir[15:12] and dec_type.
REQ-012 ALU ops (opcode 0000, 0010-0111, 0001, 1000, 1001, 1010, LD register form excluded) SHALL pulse alu_start for one cycle, then enter ALU.
REQ-013 ALU SHALL wait for alu_done; then go to WB with wb_sel=00, except CMP (1010), which SHALL return to FETCH without writeback.
REQ-014 LD immediate form (dec_type 00101) SHALL go to WB with wb_sel=01; LD register form (dec_type 00100, opcode 1011) SHALL go to MEM.
REQ-015 MEM SHALL hold mem_req=1 and mem_addr=rf_src until mem_ack; on ack: mdr<=mem_rdata, go to WB with wb_sel=10.
REQ-016 BR (1100) SHALL set pc<=pc+imm when br_taken=1 in DECODE, else leave pc unchanged; JMP (1101) SHALL always set pc<=pc+imm; both then go to FETCH.
REQ-017 imm SHALL be sign-extended ir[7:0]; pc arithmetic SHALL be 16-bit modulo (0xFFFF+1 = 0x0000), relative to the already-incremented pc.
REQ-018 CALL (1110) SHALL set pc<=pc+imm and go to WB with wb_sel=11; link value = pc before the jump (return address).
REQ-019 RET (1111) SHALL set pc<=ret_addr, go to FETCH.
REQ-020 dec_type 00000 SHALL act as NOP: DECODE to FETCH.
REQ-021 WB SHALL assert rf_we=1 for exactly one cycle, then go to FETCH; rf_we SHALL be 0 in all other states.
REQ-022 mem_ack outside FETCH/MEM and alu_done outside ALU SHALL be ignored.
REQ-023 wb_sel SHALL remain stable from entry into WB until rf_we deasserts.

Reset
REQ-024 rst=1 at a clock edge SHALL, from any state, force FETCH, pc=RESET_PC, ir=0, mdr=0, wb_sel=00, and mem_req=alu_start=rf_we=0 on the next cycle.
REQ-025 A transaction in flight at reset SHALL be abandoned; a late mem_ack or alu_done SHALL not update ir, mdr or pc.
REQ-026 Reset SHALL have priority over every other event in the same cycle.

Configuration
REQ-027 Macro RETIRE_CNT_EN defined: SHALL add output retire_cnt  out  32, reset to 0, incrementing by 1 on each transition into FETCH from a non-FETCH state, and wrapping 0xFFFFFFFF to 0.
REQ-028 RETIRE_CNT_EN undefined: the port and the counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset, then fetch 0x1283 (ADD R1,R2,R3) with 2-cycle ack delay and alu_done 3 cycles after start -> pc=0x0001, one alu_start pulse, rf_we one cycle with wb_sel=00.
REQ-030 pc=0x0010, fetch 0xC0FE (BR -2), br_taken=1 -> pc=0x000F; same with br_taken=0 -> pc=0x0011; rf_we never asserted.
REQ-031 pc=0x0020, fetch CALL imm=0x05 -> pc=0x0026, rf_we with wb_sel=11; then RET with ret_addr=0x0021 -> pc=0x0021.
REQ-032 LD register form, rf_src=0x1234, mem_rdata=0xBEEF -> mem_addr=0x1234 in MEM, mdr=0xBEEF, wb_sel=10, rf_we one cycle.
REQ-033 rst asserted while in ALU, then alu_done pulsed -> FETCH, pc=RESET_PC, no rf_we, no alu_start.
REQ-034 With RETIRE_CNT_EN: execute 5 instructions including CMP and JMP -> retire_cnt=5; pc=0xFFFF, JMP +0 -> pc=0x0000.
